// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter with stall, decode handshake, pending redirect and IDLE/RUN/HALT control.
// Optional bound checking (sticky fault on PC_LIMIT overrun or wrap) is enabled with `define FETCH_BOUND_EN.
module fetch_pc_unit #(
    parameter int unsigned   N         = 32,
    parameter int unsigned   INC       = 4,
    parameter logic [N-1:0]  RESET_VEC = '0,
    parameter logic [N-1:0]  PC_LIMIT  = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         halt_req,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         out_ready,
    output logic [N-1:0] pc,
    output logic         out_valid,
    output logic [N-1:0] pc_next,
    output logic         running,
    output logic         fault
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [N-1:0] ALIGN_MASK = ~N'(INC - 1);

    // Elaboration-time sanity check of the configuration.
    if (INC == 0 || (INC & (INC - 1)) != 0 || RESET_VEC > PC_LIMIT) begin : g_param_check
        $error("fetch_pc_unit: INC must be a power of two and RESET_VEC must not exceed PC_LIMIT");
    end

    state_t       state, state_d;
    logic [N-1:0] pc_d;
    logic         pend_valid, pend_valid_d;
    logic [N-1:0] pend_target, pend_target_d;
    logic         running_d;
    logic         fault_d;
    logic         adv;
    logic         bound_hit;
    logic [N-1:0] target_aligned;
    logic [N-1:0] pc_inc;

    assign out_valid      = running;
    assign adv            = running & out_ready & ~stall;
    assign target_aligned = branch_target & ALIGN_MASK;
    assign pc_inc         = pc + N'(INC);

    // Next-PC preview: fresh redirect, then pending redirect, then sequential.
    always_comb begin
        pc_next = pc_inc;
        if (branch_taken) begin
            pc_next = target_aligned;
        end else if (pend_valid) begin
            pc_next = pend_target;
        end
    end

    // Next-state, PC, pending buffer and fault logic.
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        pend_valid_d  = pend_valid;
        pend_target_d = pend_target;
        fault_d       = fault;
        bound_hit     = 1'b0;
`ifdef FETCH_BOUND_EN
        bound_hit = adv & ((pc_next > PC_LIMIT) |
                           (~branch_taken & ~pend_valid & (pc_inc < pc)));
`endif
        if (adv) begin
            pend_valid_d = 1'b0;
            if (bound_hit) begin
                fault_d = 1'b1;
            end else begin
                pc_d = pc_next;
            end
        end else if (branch_taken && state != IDLE) begin
            pend_valid_d  = 1'b1;
            pend_target_d = target_aligned;
        end

        unique case (state)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (halt_req || bound_hit) state_d = HALT;
            HALT:    if (start && !fault) state_d = RUN;
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_VEC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            running     <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            pend_valid  <= pend_valid_d;
            pend_target <= pend_target_d;
            running     <= running_d;
            fault       <= fault_d;
        end
    end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Parametrised program-counter/fetch-address generator at the head of the fetch stage.
- Holds the PC register and produces sequential (PC+INC) or redirected (branch target) addresses.
- Adds stall, a valid/ready handshake to decode, a pending-redirect buffer and an IDLE/RUN/HALT control FSM.
- Replaces the purely combinational next-PC select with a registered, flow-controlled unit.

Parameters:
- N, 32, PC/address width in bits.
- INC, 4, sequential increment in bytes; power of two, 1..2^(N-1).
- RESET_VEC, 0, PC value loaded on reset.
- PC_LIMIT, 2^N-1, highest legal PC; used only when FETCH_BOUND_EN is defined.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE or HALT and enter RUN.
- halt_req  in  1  request to enter HALT.
- stall  in  1  freeze PC advance (back-pressure from fetch memory).
- branch_taken  in  1  redirect request, one-cycle pulse.
- branch_target  in  N  redirect address.
- out_ready  in  1  decode accepts the current PC.
- pc  out  N  current fetch address (registered).
- out_valid  out  1  pc is valid for decode.
- pc_next  out  N  combinational preview of the PC after an advance this cycle.
- running  out  1  high while in RUN.
- fault  out  1  sticky bound violation; tied 0 without FETCH_BOUND_EN.

Behaviour:
- Reset (synchronous, rst high at the edge): pc=RESET_VEC, state=IDLE, pending buffer empty, out_valid=0, running=0, fault=0. Reset overrides every other input, including mid-advance and mid-redirect.
- FSM states and transitions:
  - IDLE: start=1 -> RUN. halt_req and branch_taken are ignored.
  - RUN: halt_req=1 -> HALT. start is ignored.
  - HALT: start=1 -> RUN. A branch_taken in HALT is captured into pending.
- out_valid = running = (state==RUN), both registered.
- Advance: adv = out_valid & out_ready & ~stall. The PC changes only on adv.
- Target alignment: the low log2(INC) bits of a redirect target are forced to 0 (aligned target, "at").
- Next-PC priority on adv:
  - branch_taken=1 -> at; pending cleared.
  - else pending valid -> pending target; pending cleared.
  - else pc+INC, truncated to N bits (wraps modulo 2^N).
- branch_taken without adv, in RUN or HALT: at is stored in pending. The latest redirect overwrites an older one. Pending survives stall and HALT and is cleared only by use or by reset.
- pc_next is combinational and shows the value the PC would take if adv is true in the current cycle, using the same priority list.
- halt_req and adv in the same cycle: the PC update is applied, then the state becomes HALT. The PC holds in HALT.
- Latency:
  - Redirect: one cycle from the adv edge to the new pc.
  - Start: out_valid rises one cycle after start is sampled, with pc unchanged.

Optional Feature:
- Macro: FETCH_BOUND_EN.
- Defined:
  - On adv, if the selected next PC > PC_LIMIT, or the increment wraps past 2^N-1: pc holds, fault<=1 (sticky until rst), state goes to HALT.
  - start is ignored while fault=1.
- Undefined: no bound check, PC wraps modulo 2^N, fault is constant 0, PC_LIMIT is unused.

Test Plan:
- Sequential fetch: N=32, INC=4, RESET_VEC=0x100. Apply rst, then start, then out_ready=1 held -> pc sequence 0x100, 0x104, 0x108, 0x10C on consecutive valid cycles; out_valid rises one cycle after start.
- Stall with redirect: at pc=0x108, set stall=1 for 3 cycles and pulse branch_taken with target 0x203 in stall cycle 2 -> pc holds 0x108 during the stall; on the first adv pc=0x200 (target aligned); then 0x204.
- Simultaneous redirects: pending holds 0x400; branch_taken with target 0x500 arrives in the same cycle as adv -> pc=0x500; pending cleared; next pc=0x504.
- Halt/resume: halt_req with adv at pc=0x10C -> pc=0x110, out_valid=0 and pc holds in HALT; start -> out_valid=1 next cycle with pc=0x110.
- Reset mid-operation: rst asserted while a redirect is pending and out_valid=1 -> next cycle pc=0x100, state IDLE, out_valid=0, pending empty; a later start gives 0x100, then 0x104 with no stale redirect.
- Wrap and bound (N=8, INC=4, RESET_VEC=0xF8, PC_LIMIT=0xFB):
  - Without FETCH_BOUND_EN: 0xF8, 0xFC, 0x00.
  - With FETCH_BOUND_EN: 0xF8, then at 0xFC fault=1, pc stays 0xF8, state HALT; start is ignored until rst.
